spi_controller: RTL and testbench



---
 rtl/spi_controller_if.sv | 21 ++
 rtl/spi_controller.sv | 80 ++++++++
 tb/tb_spi_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Request/status bundle between a requester and spi_controller.
// master = requester side, slave = controller side.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, busy, done
    );
endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI write initiator: shifts one 16-bit frame {rw, addr[6:0], data[7:0]}
// MSB first per accepted request, paced by CLK_DIV clk cycles per sCLK level.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ncs high, waiting for req_valid (req_ready = 1)
// LEAD   | ncs low, copi shows frame[15], setup before first rise
// HIGH   | sclk high, copi held; peripheral samples here
// LOW    | sclk low, next bit launched on entry (zero after bit 0)
// GAP    | ncs high deselect time, done pulses on first cycle
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus,
    output logic             sclk,
    output logic             ncs,
    output logic             copi
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BITS_LAST  = 5'd16;

    logic [2:0]  state;
    logic [7:0]  phase_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        phase_end;

    assign phase_end = (phase_cnt == PHASE_LAST);

    // Sequencer: accept in IDLE, otherwise step phases every CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= 8'd0;
            bit_cnt   <= 5'd0;
            shift_reg <= 16'd0;
        end else if (state == S_IDLE) begin
            phase_cnt <= 8'd0;
            if (bus.req_valid) begin
                shift_reg <= {bus.req_rw, bus.req_addr, bus.req_data};
                bit_cnt   <= 5'd0;
                state     <= S_LEAD;
            end
        end else if (!phase_end) begin
            phase_cnt <= phase_cnt + 8'd1;
        end else begin
            phase_cnt <= 8'd0;
            case (state)
                S_LEAD: state <= S_HIGH;
                S_HIGH: begin
                    // Falling-edge launch: shifting in zeros leaves copi low after bit 0.
                    state     <= S_LOW;
                    bit_cnt   <= bit_cnt + 5'd1;
                    shift_reg <= {shift_reg[14:0], 1'b0};
                end
                S_LOW:   state <= (bit_cnt == BITS_LAST) ? S_GAP : S_HIGH;
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; no input-to-output paths.
    assign sclk          = (state == S_HIGH);
    assign ncs           = !((state == S_LEAD) || (state == S_HIGH) || (state == S_LOW));
    assign copi          = shift_reg[15];
    assign bus.busy      = (state != S_IDLE);
    assign bus.req_ready = (state == S_IDLE);
    assign bus.done      = (state == S_GAP) && (phase_cnt == 8'd0);

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV 4 and 7), a timing model
// built from the frame timing formulas, and a loopback receiver register model.
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    spi_controller_if bus0 ();
    spi_controller_if bus1 ();

    logic sclk0, ncs0, copi0, sclk1, ncs1, copi1;

    spi_controller #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .sclk(sclk0), .ncs(ncs0), .copi(copi0)
    );
    spi_controller #(.CLK_DIV(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .sclk(sclk1), .ncs(ncs1), .copi(copi1)
    );

    int         sel;
    logic       drv_valid, drv_rw;
    logic [6:0] drv_addr;
    logic [7:0] drv_data;

    assign bus0.req_valid = drv_valid && (sel == 0);
    assign bus0.req_rw    = drv_rw;
    assign bus0.req_addr  = drv_addr;
    assign bus0.req_data  = drv_data;
    assign bus1.req_valid = drv_valid && (sel == 1);
    assign bus1.req_rw    = drv_rw;
    assign bus1.req_addr  = drv_addr;
    assign bus1.req_data  = drv_data;

    logic p_sclk, p_ncs, p_copi, p_done, p_busy, p_ready;
    assign p_sclk  = (sel == 0) ? sclk0 : sclk1;
    assign p_ncs   = (sel == 0) ? ncs0  : ncs1;
    assign p_copi  = (sel == 0) ? copi0 : copi1;
    assign p_done  = (sel == 0) ? bus0.done      : bus1.done;
    assign p_busy  = (sel == 0) ? bus0.busy      : bus1.busy;
    assign p_ready = (sel == 0) ? bus0.req_ready : bus1.req_ready;

    // Loopback receiver: samples on sclk rise, commits full write frames on ncs rise.
    logic [7:0]  periph   [128];
    logic [7:0]  exp_regs [128];
    logic [15:0] rx_sr = 16'd0;
    int          rx_n = 0;

    always @(posedge p_sclk) begin
        if (!p_ncs) begin
            rx_sr = {rx_sr[14:0], p_copi};
            rx_n  = rx_n + 1;
        end
    end

    always @(posedge p_ncs) begin
        if (rx_n == 16 && rx_sr[15]) periph[rx_sr[14:8]] = rx_sr[7:0];
        rx_n = 0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ncs"},   p_ncs,   1);
        chk({tag, "_sclk"},  p_sclk,  0);
        chk({tag, "_copi"},  p_copi,  0);
        chk({tag, "_done"},  p_done,  0);
        chk({tag, "_busy"},  p_busy,  0);
        chk({tag, "_ready"}, p_ready, 1);
    endtask

    task automatic start_frame(input logic [15:0] word);
        int n = 0;
        @(negedge clk);
        while (!p_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", p_ready, 1);
        {drv_rw, drv_addr, drv_data} = word;
        drv_valid = 1'b1;
    endtask

    // Observe cycles 1..34H+1 after the accept edge and compare to the timing model.
    task automatic run_frame(input logic [15:0] word, input bit keep_valid,
                             input logic [15:0] next_word, input int pulse_at,
                             output int first_ready, output int gap_hi);
        int h = (sel == 0) ? 4 : 7;
        int e_ncs = 0, e_sclk = 0, e_copi = 0, e_done = 0, e_busy = 0, e_ready = 0;
        int low_cnt = 0, done_cyc = -1, rises = 0;
        logic [15:0] got = 16'd0;
        logic prev_sclk = 1'b0;
        logic x_ncs, x_sclk, x_copi, x_done, x_busy;
        first_ready = -1;
        gap_hi = 0;
        for (int c = 1; c <= 34*h + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (keep_valid) {drv_rw, drv_addr, drv_data} = next_word;
                else drv_valid = 1'b0;
            end
            if (pulse_at > 0 && c == pulse_at) begin
                {drv_rw, drv_addr, drv_data} = ~word;
                drv_valid = 1'b1;
            end
            if (pulse_at > 0 && c == pulse_at + 1) drv_valid = 1'b0;

            x_ncs  = !(c <= 33*h);
            x_sclk = (c > h) && (c <= 33*h) && (((c - h - 1) % (2*h)) < h);
            x_copi = (c <= 32*h) ? word[15 - (c - 1) / (2*h)] : 1'b0;
            x_done = (c == 33*h + 1);
            x_busy = (c <= 34*h);

            if (p_ncs   !== x_ncs)   e_ncs++;
            if (p_sclk  !== x_sclk)  e_sclk++;
            if (p_copi  !== x_copi)  e_copi++;
            if (p_done  !== x_done)  e_done++;
            if (p_busy  !== x_busy)  e_busy++;
            if (p_ready !== !x_busy) e_ready++;

            if (!p_ncs) low_cnt++;
            if (p_done && done_cyc < 0) done_cyc = c;
            if (p_ready && first_ready < 0) first_ready = c;
            if (c > 33*h && p_ncs) gap_hi++;
            if (p_sclk && !prev_sclk) begin
                rises++;
                got = {got[14:0], p_copi};
            end
            prev_sclk = p_sclk;
        end
        chk("ncs_wave",       e_ncs,   0);
        chk("sclk_wave",      e_sclk,  0);
        chk("copi_wave",      e_copi,  0);
        chk("done_wave",      e_done,  0);
        chk("busy_wave",      e_busy,  0);
        chk("ready_wave",     e_ready, 0);
        chk("ncs_low_cycles", low_cnt, 33*h);
        chk("done_cycle",     done_cyc, 33*h + 1);
        chk("sclk_rises",     rises,   16);
        chk("frame_bits",     got,     word);
        chk("ready_back",     first_ready, 34*h + 1);
    endtask

    task automatic update_and_check_periph(input logic [15:0] word);
        if (word[15]) exp_regs[word[14:8]] = word[7:0];
        chk("periph_reg", periph[word[14:8]], exp_regs[word[14:8]]);
    endtask

    task automatic do_frame(input logic [15:0] word, input int pulse_at);
        int fr, gap;
        start_frame(word);
        run_frame(word, 1'b0, 16'h0000, pulse_at, fr, gap);
        update_and_check_periph(word);
    endtask

    initial begin
        logic [15:0] w1, w2, wr;
        int fr, gap, rises, dones, n;
        logic prev;

        for (int i = 0; i < 128; i++) begin
            periph[i]   = 8'h00;
            exp_regs[i] = 8'h00;
        end
        sel = 0;
        drv_valid = 1'b0;
        {drv_rw, drv_addr, drv_data} = 16'h0000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 0; #1 chk_reset_vals("rst_h4");
        sel = 1; #1 chk_reset_vals("rst_h7");
        sel = 0;

        // Single write frame, H=4
        do_frame({1'b1, 7'h02, 8'hA5}, 0);

        // Back-to-back writes with req_valid held
        w1 = {1'b1, 7'h00, 8'hFF};
        w2 = {1'b1, 7'h04, 8'h80};
        start_frame(w1);
        run_frame(w1, 1'b1, w2, 0, fr, gap);
        chk("b2b_spacing", fr, 137);
        chk("b2b_gap_ge4", (gap >= 4) ? 1 : 0, 1);
        update_and_check_periph(w1);
        run_frame(w2, 1'b0, 16'h0000, 0, fr, gap);
        update_and_check_periph(w2);

        // Read frame leaves the register untouched
        do_frame({1'b0, 7'h01, 8'h3C}, 0);

        // Reset after the 9th sclk rise
        w1 = {1'b1, 7'h05, 8'h5A};
        start_frame(w1);
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 9 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) drv_valid = 1'b0;
            if (p_sclk && !prev) rises++;
            prev = p_sclk;
        end
        chk("rst_mid_rises", rises, 9);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        rst_n = 1'b1;
        rises = 0; dones = 0; prev = p_sclk;
        repeat (60) begin
            @(negedge clk);
            if (p_sclk && !prev) rises++;
            if (p_done) dones++;
            prev = p_sclk;
        end
        chk("rst_mid_no_sclk", rises, 0);
        chk("rst_mid_no_done", dones, 0);
        chk("rst_mid_periph", periph[5], exp_regs[5]);

        // Request pulsed while busy has no effect
        do_frame({1'b1, 7'h10, 8'h5C}, 40);
        repeat (10) @(negedge clk);
        chk("busy_pulse_idle", p_busy, 0);

        // Single write frame, H=7
        sel = 1;
        do_frame({1'b1, 7'h02, 8'hA5}, 0);

        // Randomized frames on both dividers, some with stray requests mid-frame
        for (int i = 0; i < 6; i++) begin
            sel = i % 2;
            wr = 16'($urandom);
            do_frame(wr, ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 100)) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
